// File: rtl/sb_config_loader.sv
`default_nettype none
// ============================================================================
//  Module      : sb_config_loader
//  Description : Feeds the switchbox configuration chain. Accepts host words
//                over valid/ready, shifts them MSB-first onto config_data with
//                config_en, and stops after exactly total_bits shifts. A one
//                word prefetch buffer keeps config_en continuously high when
//                the host keeps up.
//  Revision    : 1.0 - initial release
// ============================================================================
module sb_config_loader #(
    parameter int WORD_W = 32,
    parameter int CNT_W  = 24
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              start,
    input  logic [CNT_W-1:0]  total_bits,
    input  logic              abort,
    input  logic [WORD_W-1:0] word_data,
    input  logic              word_valid,
    output logic              word_ready,
    output logic              config_en,
    output logic              config_data,
    output logic              busy,
    output logic              done,
    output logic              underrun
);

    localparam int                c_sc_w      = $clog2(WORD_W + 1);
    localparam logic [c_sc_w-1:0] c_word_bits = c_sc_w'(WORD_W);
    localparam logic [CNT_W:0]    c_word_step = (CNT_W + 1)'(WORD_W);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nx;

    logic [CNT_W-1:0]    r_total;
    logic [CNT_W-1:0]    r_bits_sent;
    // Bits accepted from the host so far, one bit wider so the final word
    // can overshoot total_bits without wrapping.
    logic [CNT_W:0]      r_bits_acc;
    logic [WORD_W-1:0]   r_sr;
    logic [c_sc_w-1:0]   r_sr_cnt;
    logic [WORD_W-1:0]   r_buf;
    logic                r_buf_full;
    logic                r_cfg_en;
    logic                r_cfg_data;
    logic                r_done;
    logic                r_underrun;

    logic                w_run;
    logic                w_start_acc;
    logic                w_accept;
    logic                w_shift;
    logic                w_last;
    logic                w_stall;
    logic                w_sr_refill;

    assign w_run       = (r_state == S_RUN);
    assign w_start_acc = (r_state == S_IDLE) && start;
    assign w_accept    = word_ready && word_valid;
    assign w_shift     = w_run && !abort && (r_sr_cnt != '0);
    assign w_last      = w_shift && ((r_bits_sent + CNT_W'(1)) == r_total);
    // A lost shift only counts once the host has delivered its first word.
    assign w_stall     = w_run && !abort && (r_sr_cnt == '0) && (r_bits_acc != '0);
    // SR holds no bits after this edge, so it must be refilled now to avoid a bubble.
    assign w_sr_refill = (r_sr_cnt == '0) || (w_shift && (r_sr_cnt == c_sc_w'(1)));

    assign busy        = (r_state != S_IDLE);
    assign done        = r_done;
    assign underrun    = r_underrun;
    assign config_en   = r_cfg_en;
    assign config_data = r_cfg_data;

    // State register
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // Next-state decode and host ready
    always_comb begin
        w_state_nx = r_state;
        word_ready = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nx = (total_bits == '0) ? S_FIN : S_RUN;
                end
            end
            S_RUN: begin
                word_ready = !abort && !r_buf_full && (r_bits_acc < {1'b0, r_total});
                if (abort) begin
                    w_state_nx = S_IDLE;
                end else if (w_last) begin
                    w_state_nx = S_FIN;
                end
            end
            S_FIN: begin
                w_state_nx = S_IDLE;
            end
            default: begin
                w_state_nx = S_IDLE;
            end
        endcase
    end

    // Shift register, prefetch buffer, counters and chain outputs
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_total     <= '0;
            r_bits_sent <= '0;
            r_bits_acc  <= '0;
            r_sr        <= '0;
            r_sr_cnt    <= '0;
            r_buf       <= '0;
            r_buf_full  <= 1'b0;
            r_cfg_en    <= 1'b0;
            r_cfg_data  <= 1'b0;
            r_done      <= 1'b0;
            r_underrun  <= 1'b0;
        end else begin
            r_done   <= (r_state == S_FIN);
            r_cfg_en <= w_shift;
            if (w_shift) begin
                r_cfg_data <= r_sr[WORD_W-1];
            end

            if (w_start_acc) begin
                r_total     <= total_bits;
                r_bits_sent <= '0;
                r_bits_acc  <= '0;
                r_sr_cnt    <= '0;
                r_buf_full  <= 1'b0;
                r_underrun  <= 1'b0;
            end else if (w_run && abort) begin
                r_sr_cnt   <= '0;
                r_buf_full <= 1'b0;
            end else if (w_run) begin
                if (w_stall) begin
                    r_underrun <= 1'b1;
                end
                if (w_shift) begin
                    r_bits_sent <= r_bits_sent + CNT_W'(1);
                    r_sr        <= {r_sr[WORD_W-2:0], 1'b0};
                    r_sr_cnt    <= r_sr_cnt - c_sc_w'(1);
                end
                if (w_accept) begin
                    r_bits_acc <= r_bits_acc + c_word_step;
                end
                if (w_sr_refill) begin
                    if (r_buf_full) begin
                        r_sr       <= r_buf;
                        r_sr_cnt   <= c_word_bits;
                        r_buf_full <= 1'b0;
                    end else if (w_accept) begin
                        r_sr     <= word_data;
                        r_sr_cnt <= c_word_bits;
                    end
                end else if (w_accept) begin
                    r_buf      <= word_data;
                    r_buf_full <= 1'b1;
                end
                // Final shift: whatever is left of the last word is dropped.
                if (w_last) begin
                    r_sr_cnt   <= '0;
                    r_buf_full <= 1'b0;
                end
            end
        end
    end

endmodule
`default_nettype wire
